// File: rtl/keccak_stream_padder_pkg.sv
// keccak_pkg: shared types and constants for the Keccak stream padder.
//   mode_t       - hash mode selector (SHA3-224/256/384/512, SHAKE128/256)
//   RATE_BYTES_* - block rate in bytes per mode
//   DOM_SHA3, DOM_SHAKE, PAD_END - pad10*1 domain and terminator bytes
//   decode_mode(), rate_bytes(), domain_byte() - mode helpers
package keccak_pkg;

    typedef enum logic [2:0] {
        MODE_SHA3_224 = 3'd0,
        MODE_SHA3_256 = 3'd1,
        MODE_SHA3_384 = 3'd2,
        MODE_SHA3_512 = 3'd3,
        MODE_SHAKE128 = 3'd4,
        MODE_SHAKE256 = 3'd5
    } mode_t;

    // Byte pointer width: covers 0..168 (largest rate).
    localparam int PTR_W = 8;

    localparam logic [7:0] RATE_BYTES_SHA3_224 = 8'd144;
    localparam logic [7:0] RATE_BYTES_SHA3_256 = 8'd136;
    localparam logic [7:0] RATE_BYTES_SHA3_384 = 8'd104;
    localparam logic [7:0] RATE_BYTES_SHA3_512 = 8'd72;
    localparam logic [7:0] RATE_BYTES_SHAKE128 = 8'd168;
    localparam logic [7:0] RATE_BYTES_SHAKE256 = 8'd136;

    localparam logic [7:0] DOM_SHA3  = 8'h06;
    localparam logic [7:0] DOM_SHAKE = 8'h1F;
    localparam logic [7:0] PAD_END   = 8'h80;

    // Unused codes 6 and 7 fall back to SHA3-256.
    function automatic mode_t decode_mode(input logic [2:0] code);
        case (code)
            3'd0:    return MODE_SHA3_224;
            3'd1:    return MODE_SHA3_256;
            3'd2:    return MODE_SHA3_384;
            3'd3:    return MODE_SHA3_512;
            3'd4:    return MODE_SHAKE128;
            3'd5:    return MODE_SHAKE256;
            default: return MODE_SHA3_256;
        endcase
    endfunction

    function automatic logic [7:0] rate_bytes(input mode_t m);
        case (m)
            MODE_SHA3_224: return RATE_BYTES_SHA3_224;
            MODE_SHA3_256: return RATE_BYTES_SHA3_256;
            MODE_SHA3_384: return RATE_BYTES_SHA3_384;
            MODE_SHA3_512: return RATE_BYTES_SHA3_512;
            MODE_SHAKE128: return RATE_BYTES_SHAKE128;
            MODE_SHAKE256: return RATE_BYTES_SHAKE256;
            default:       return RATE_BYTES_SHA3_256;
        endcase
    endfunction

    function automatic logic [7:0] domain_byte(input mode_t m);
        if (m == MODE_SHAKE128 || m == MODE_SHAKE256) return DOM_SHAKE;
        return DOM_SHA3;
    endfunction

endpackage

// File: rtl/keccak_stream_padder_if.sv
// keccak_stream_padder_if: message-in and block-out handshakes of the padder.
//   in_valid/in_ready/in_data/in_nbytes/in_last - byte stream, IN_BYTES per beat
//   blk_valid/blk_ready/blk_data/blk_last       - rate-sized blocks to absorb stage
// Modports: master = environment (source of bytes, sink of blocks),
//           slave  = the padder.
interface keccak_stream_padder_if #(
    parameter int IN_BYTES = 8,
    parameter int MAX_RATE = 1344
) ();
    logic                               in_valid;
    logic                               in_ready;
    logic [8*IN_BYTES-1:0]              in_data;
    logic [$clog2(IN_BYTES+1)-1:0]      in_nbytes;
    logic                               in_last;
    logic                               blk_valid;
    logic                               blk_ready;
    logic [MAX_RATE-1:0]                blk_data;
    logic                               blk_last;

    modport master (
        output in_valid, in_data, in_nbytes, in_last, blk_ready,
        input  in_ready, blk_valid, blk_data, blk_last
    );

    modport slave (
        input  in_valid, in_data, in_nbytes, in_last, blk_ready,
        output in_ready, blk_valid, blk_data, blk_last
    );
endinterface

// File: rtl/keccak_stream_padder_rate_buffer.sv
// keccak_rate_buffer: byte-addressable MAX_RATE-bit block register.
//   clk, rst_n     - clock, synchronous active-low reset (clears buffer)
//   clr            - clear whole buffer (applied before write/pad this cycle)
//   wr_en, wr_ptr, wr_data, wr_nbytes - write wr_nbytes low bytes at wr_ptr
//   pad_en, pad_ptr, pad_end, dom     - OR dom into pad_ptr and 0x80 into pad_end
//   data_o         - current buffer contents
module keccak_rate_buffer
    import keccak_pkg::*;
#(
    parameter int IN_BYTES = 8,
    parameter int MAX_RATE = 1344,
    parameter int NB_W     = $clog2(IN_BYTES + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [PTR_W-1:0]      wr_ptr,
    input  logic [8*IN_BYTES-1:0] wr_data,
    input  logic [NB_W-1:0]       wr_nbytes,
    input  logic                  pad_en,
    input  logic [PTR_W-1:0]      pad_ptr,
    input  logic [PTR_W-1:0]      pad_end,
    input  logic [7:0]            dom,
    output logic [MAX_RATE-1:0]   data_o
);

    logic [MAX_RATE-1:0] rbuf_q, rbuf_d;

    // Write then pad in the same cycle: the pad OR sees the freshly
    // written bytes, and when pad_ptr == pad_end both marks merge.
    always_comb begin
        rbuf_d = rbuf_q;
        if (clr) rbuf_d = '0;
        if (wr_en) begin
            for (int k = 0; k < IN_BYTES; k++) begin
                if (k < int'(wr_nbytes))
                    rbuf_d[(int'(wr_ptr) + k)*8 +: 8] = wr_data[k*8 +: 8];
            end
        end
        if (pad_en) begin
            rbuf_d[int'(pad_ptr)*8 +: 8] = rbuf_d[int'(pad_ptr)*8 +: 8] | dom;
            rbuf_d[int'(pad_end)*8 +: 8] = rbuf_d[int'(pad_end)*8 +: 8] | PAD_END;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) rbuf_q <= '0;
        else        rbuf_q <= rbuf_d;
    end

    assign data_o = rbuf_q;

endmodule

// File: rtl/keccak_stream_padder.sv
// keccak_stream_padder: streaming Keccak pad10*1 padder, SHA3 and SHAKE modes.
//   clk, rst_n - clock, synchronous active-low reset
//   mode       - 0..5 = SHA3-224/256/384/512, SHAKE128/256 (6,7 -> SHA3-256),
//                latched on the first accepted beat of a message
//   bus        - slave side of the byte-in / block-out handshakes
//   busy       - a message is in progress
//
// state  | meaning
// IDLE   | waiting for first beat of a message, mode taken from input
// ACCUM  | collecting beats into the rate buffer
// EMIT   | block offered downstream, input stalled
// PADBLK | building the extra pad-only block after a boundary-aligned message
module keccak_stream_padder
    import keccak_pkg::*;
#(
    parameter int IN_BYTES = 8,
    parameter int MAX_RATE = 1344
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [2:0]             mode,
    keccak_stream_padder_if.slave  bus,
    output logic                   busy
);

    localparam int NB_W = $clog2(IN_BYTES + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCUM  = 2'd1;
    localparam logic [1:0] ST_EMIT   = 2'd2;
    localparam logic [1:0] ST_PADBLK = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    mode_t            mode_q, mode_d;
    logic             last_q, last_d;
    logic             pend_q, pend_d;
    logic             busy_q, busy_d;

    mode_t            cur_mode;
    logic [7:0]       rate;
    logic [7:0]       dom;
    logic             accepting;
    logic             in_fire;
    logic [PTR_W-1:0] ptr_sum;

    logic             wr_en;
    logic             clr;
    logic             pad_en;
    logic [PTR_W-1:0] pad_ptr;

    // In IDLE the mode input applies to the beat being accepted; afterwards
    // the latched copy is used so mid-message changes are ignored.
    assign cur_mode  = (state_q == ST_IDLE) ? decode_mode(mode) : mode_q;
    assign rate      = rate_bytes(cur_mode);
    assign dom       = domain_byte(cur_mode);
    assign accepting = rst_n && (state_q == ST_IDLE || state_q == ST_ACCUM);
    assign in_fire   = bus.in_valid && accepting;
    assign ptr_sum   = ptr_q + {{(PTR_W-NB_W){1'b0}}, bus.in_nbytes};

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        mode_d  = mode_q;
        last_d  = last_q;
        pend_d  = pend_q;
        busy_d  = busy_q;
        wr_en   = 1'b0;
        clr     = 1'b0;
        pad_en  = 1'b0;
        pad_ptr = ptr_sum;
        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (in_fire) begin
                    wr_en  = 1'b1;
                    mode_d = cur_mode;
                    busy_d = 1'b1;
                    ptr_d  = ptr_sum;
                    if (ptr_sum == rate) begin
                        // Full block; if the message also ends here the
                        // padding needs a block of its own.
                        state_d = ST_EMIT;
                        last_d  = 1'b0;
                        pend_d  = bus.in_last;
                    end else if (bus.in_last) begin
                        pad_en  = 1'b1;
                        state_d = ST_EMIT;
                        last_d  = 1'b1;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
            end
            ST_EMIT: begin
                if (bus.blk_ready) begin
                    clr   = 1'b1;
                    ptr_d = '0;
                    if (pend_q) begin
                        pend_d  = 1'b0;
                        state_d = ST_PADBLK;
                    end else if (last_q) begin
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
            end
            ST_PADBLK: begin
                // Buffer was cleared at the previous handshake.
                pad_en  = 1'b1;
                pad_ptr = '0;
                last_d  = 1'b1;
                state_d = ST_EMIT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            mode_q  <= MODE_SHA3_256;
            last_q  <= 1'b0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            mode_q  <= mode_d;
            last_q  <= last_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
        end
    end

    keccak_rate_buffer #(
        .IN_BYTES (IN_BYTES),
        .MAX_RATE (MAX_RATE),
        .NB_W     (NB_W)
    ) u_rate_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .wr_en     (wr_en),
        .wr_ptr    (ptr_q),
        .wr_data   (bus.in_data),
        .wr_nbytes (bus.in_nbytes),
        .pad_en    (pad_en),
        .pad_ptr   (pad_ptr),
        .pad_end   (rate - 8'd1),
        .dom       (dom),
        .data_o    (bus.blk_data)
    );

    assign bus.in_ready  = accepting;
    assign bus.blk_valid = (state_q == ST_EMIT);
    assign bus.blk_last  = last_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_keccak_stream_padder.sv
// Testbench for keccak_stream_padder: random and directed messages, blocks
// checked against a pad10*1 reference built from whole-message byte queues.
module tb_keccak_stream_padder;

    localparam int IN_BYTES = 8;
    localparam int MAX_RATE = 1344;

    typedef struct {
        logic [MAX_RATE-1:0] data;
        logic                last;
    } blk_t;

    logic       clk;
    logic       rst_n;
    logic [2:0] mode;
    logic       busy;

    keccak_stream_padder_if #(.IN_BYTES(IN_BYTES), .MAX_RATE(MAX_RATE)) bus ();

    keccak_stream_padder #(.IN_BYTES(IN_BYTES), .MAX_RATE(MAX_RATE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mode  (mode),
        .bus   (bus),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int                  tests;
    int                  fails;
    blk_t                exp_q[$];
    logic [7:0]          msg_q[$];
    int                  blk_count;
    logic [MAX_RATE-1:0] cap_data;
    logic                cap_last;
    logic                held_v;
    logic [MAX_RATE-1:0] held_data;
    logic                held_last;
    bit                  stall5;
    int                  stall_cnt;

    task automatic check(input string name, input logic [MAX_RATE-1:0] act,
                         input logic [MAX_RATE-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] byte_at(input logic [MAX_RATE-1:0] d, input int i);
        return d[i*8 +: 8];
    endfunction

    function automatic int rate_of(input int m);
        case (m)
            0: return 144;
            1: return 136;
            2: return 104;
            3: return 72;
            4: return 168;
            5: return 136;
            default: return 136;
        endcase
    endfunction

    // Reference: pad the whole message to a multiple of R, then chop.
    task automatic push_expected(input int m);
        int         r, len, nblk, idx;
        logic [7:0] d, v;
        blk_t       b;
        r    = rate_of(m);
        d    = (m == 4 || m == 5) ? 8'h1F : 8'h06;
        len  = msg_q.size();
        nblk = len / r + 1;
        for (int bi = 0; bi < nblk; bi++) begin
            b.data = '0;
            for (int i = 0; i < r; i++) begin
                idx = bi*r + i;
                v = (idx < len) ? msg_q[idx] : 8'h00;
                if (idx == len) v = v | d;
                if (idx == nblk*r - 1) v = v | 8'h80;
                b.data[i*8 +: 8] = v;
            end
            b.last = (bi == nblk - 1);
            exp_q.push_back(b);
        end
    endtask

    // fill < 0 gives random bytes; full=0 sends len bytes without in_last.
    task automatic send_msg(input int m, input int len, input int fill, input bit full);
        int  pos, rem, n, c;
        bit  lst, done, acc;
        @(posedge clk); #1;
        msg_q.delete();
        for (int i = 0; i < len; i++)
            msg_q.push_back((fill < 0) ? 8'($urandom_range(0, 255)) : 8'(fill));
        if (full) push_expected(m);
        mode = 3'(m);
        pos  = 0;
        done = 0;
        while (!done) begin
            rem = len - pos;
            n   = (rem > IN_BYTES) ? IN_BYTES : rem;
            lst = full && (rem <= IN_BYTES);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            for (int k = 0; k < IN_BYTES; k++)
                bus.in_data[k*8 +: 8] = (k < n) ? msg_q[pos+k] : 8'($urandom_range(0, 255));
            bus.in_nbytes = 4'(n);
            bus.in_last   = lst;
            bus.in_valid  = 1'b1;
            c   = 0;
            acc = 0;
            while (!acc && c < 2000) begin
                @(negedge clk);
                acc = bus.in_ready;
                @(posedge clk); #1;
                c++;
            end
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b0;
            if (!acc) begin
                tests++; fails++;
                $display("FAIL beat_accept_timeout: in_ready never 1 within 2000 cycles");
                done = 1;
            end
            mode = 3'($urandom_range(0, 7));
            pos  = pos + n;
            if (lst || (!full && pos >= len)) done = 1;
        end
    endtask

    task automatic wait_drain(input string name);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 5000) begin @(posedge clk); c++; end
        if (exp_q.size() != 0) begin
            tests++; fails++;
            $display("FAIL %s_drain_timeout: %0d blocks outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        @(negedge clk);
        check({name, "_busy_after"}, MAX_RATE'(busy), MAX_RATE'(1'b0));
        check({name, "_in_ready_after"}, MAX_RATE'(bus.in_ready), MAX_RATE'(1'b1));
    endtask

    initial begin
        int   b0;
        blk_t e;
        tests = 0; fails = 0; blk_count = 0;
        held_v = 0; stall5 = 0; stall_cnt = 0;
        cap_data = '0; cap_last = 0; held_data = '0; held_last = 0;
        rst_n = 1'b0; mode = 3'd1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_nbytes = '0; bus.in_last = 1'b0;
        bus.blk_ready = 1'b0;

        // Block sink: random ready, or exactly 5 stall cycles per block.
        fork
            forever begin
                @(posedge clk); #1;
                if (bus.blk_valid) begin
                    if (stall5) begin
                        bus.blk_ready = (stall_cnt >= 5);
                        stall_cnt++;
                    end else begin
                        bus.blk_ready = ($urandom_range(0, 3) != 0);
                    end
                end else begin
                    stall_cnt = 0;
                    bus.blk_ready = stall5 ? 1'b0 : ($urandom_range(0, 1) == 1);
                end
            end
            // Output monitor: stability, no input overlap, scoreboard compare.
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    held_v = 0;
                end else if (bus.blk_valid) begin
                    check("in_ready_during_emit", MAX_RATE'(bus.in_ready), MAX_RATE'(1'b0));
                    check("busy_during_emit", MAX_RATE'(busy), MAX_RATE'(1'b1));
                    if (held_v) begin
                        check("blk_data_stable", bus.blk_data, held_data);
                        check("blk_last_stable", MAX_RATE'(bus.blk_last), MAX_RATE'(held_last));
                    end
                    if (bus.blk_ready) begin
                        if (exp_q.size() == 0) begin
                            tests++; fails++;
                            $display("FAIL unexpected_block: got block data %0h, required none", bus.blk_data);
                        end else begin
                            e = exp_q.pop_front();
                            check("blk_data", bus.blk_data, e.data);
                            check("blk_last", MAX_RATE'(bus.blk_last), MAX_RATE'(e.last));
                        end
                        cap_data  = bus.blk_data;
                        cap_last  = bus.blk_last;
                        blk_count++;
                        held_v = 0;
                    end else begin
                        held_v    = 1;
                        held_data = bus.blk_data;
                        held_last = bus.blk_last;
                    end
                end else begin
                    held_v = 0;
                end
            end
        join_none

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", MAX_RATE'(bus.in_ready), MAX_RATE'(1'b0));
        check("rst_blk_valid", MAX_RATE'(bus.blk_valid), MAX_RATE'(1'b0));
        check("rst_blk_last", MAX_RATE'(bus.blk_last), MAX_RATE'(1'b0));
        check("rst_blk_data", bus.blk_data, '0);
        check("rst_busy", MAX_RATE'(busy), MAX_RATE'(1'b0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", MAX_RATE'(bus.in_ready), MAX_RATE'(1'b1));

        // Empty SHA3-256 message.
        b0 = blk_count;
        send_msg(1, 0, -1, 1);
        wait_drain("empty");
        check("empty_nblk", MAX_RATE'(blk_count - b0), MAX_RATE'(1));
        check("empty_b0", MAX_RATE'(byte_at(cap_data, 0)), MAX_RATE'(8'h06));
        check("empty_b135", MAX_RATE'(byte_at(cap_data, 135)), MAX_RATE'(8'h80));
        check("empty_b1", MAX_RATE'(byte_at(cap_data, 1)), MAX_RATE'(8'h00));
        check("empty_last", MAX_RATE'(cap_last), MAX_RATE'(1'b1));

        // Pointer ends at R-1: merged 0x86.
        b0 = blk_count;
        send_msg(1, 135, 8'hA5, 1);
        wait_drain("rm1");
        check("rm1_nblk", MAX_RATE'(blk_count - b0), MAX_RATE'(1));
        check("rm1_b134", MAX_RATE'(byte_at(cap_data, 134)), MAX_RATE'(8'hA5));
        check("rm1_b135", MAX_RATE'(byte_at(cap_data, 135)), MAX_RATE'(8'h86));
        check("rm1_b136", MAX_RATE'(byte_at(cap_data, 136)), MAX_RATE'(8'h00));

        // Exact boundary: extra pad block.
        b0 = blk_count;
        send_msg(1, 136, -1, 1);
        wait_drain("bnd");
        check("bnd_nblk", MAX_RATE'(blk_count - b0), MAX_RATE'(2));
        check("bnd_b0", MAX_RATE'(byte_at(cap_data, 0)), MAX_RATE'(8'h06));
        check("bnd_b135", MAX_RATE'(byte_at(cap_data, 135)), MAX_RATE'(8'h80));
        check("bnd_last", MAX_RATE'(cap_last), MAX_RATE'(1'b1));

        // SHAKE128 "abc".
        b0 = blk_count;
        send_msg(4, 0, -1, 0);
        msg_q.delete();
        msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
        push_expected(4);
        @(posedge clk); #1;
        mode = 3'd4;
        bus.in_data = {40'h0, 8'h63, 8'h62, 8'h61};
        bus.in_nbytes = 4'd3; bus.in_last = 1'b1; bus.in_valid = 1'b1;
        @(negedge clk);
        check("abc_in_ready", MAX_RATE'(bus.in_ready), MAX_RATE'(1'b1));
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.in_last = 1'b0;
        wait_drain("abc");
        check("abc_nblk", MAX_RATE'(blk_count - b0), MAX_RATE'(1));
        check("abc_b2", MAX_RATE'(byte_at(cap_data, 2)), MAX_RATE'(8'h63));
        check("abc_b3", MAX_RATE'(byte_at(cap_data, 3)), MAX_RATE'(8'h1F));
        check("abc_b166", MAX_RATE'(byte_at(cap_data, 166)), MAX_RATE'(8'h00));
        check("abc_b167", MAX_RATE'(byte_at(cap_data, 167)), MAX_RATE'(8'h80));

        // Backpressure: SHA3-512, 300 bytes, 5-cycle stall per block.
        stall5 = 1;
        b0 = blk_count;
        send_msg(3, 300, -1, 1);
        wait_drain("bp");
        stall5 = 0;
        check("bp_nblk", MAX_RATE'(blk_count - b0), MAX_RATE'(5));
        check("bp_b12", MAX_RATE'(byte_at(cap_data, 12)), MAX_RATE'(8'h06));
        check("bp_b71", MAX_RATE'(byte_at(cap_data, 71)), MAX_RATE'(8'h80));
        check("bp_b72", MAX_RATE'(byte_at(cap_data, 72)), MAX_RATE'(8'h00));

        // Reset mid-message, then empty SHA3-224.
        send_msg(1, 40, -1, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", MAX_RATE'(bus.in_ready), MAX_RATE'(1'b0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_in_ready_after", MAX_RATE'(bus.in_ready), MAX_RATE'(1'b1));
        check("midrst_blk_valid", MAX_RATE'(bus.blk_valid), MAX_RATE'(1'b0));
        check("midrst_busy", MAX_RATE'(busy), MAX_RATE'(1'b0));
        b0 = blk_count;
        send_msg(0, 0, -1, 1);
        wait_drain("midrst");
        check("midrst_nblk", MAX_RATE'(blk_count - b0), MAX_RATE'(1));
        check("midrst_b0", MAX_RATE'(byte_at(cap_data, 0)), MAX_RATE'(8'h06));
        check("midrst_b143", MAX_RATE'(byte_at(cap_data, 143)), MAX_RATE'(8'h80));
        check("midrst_b5", MAX_RATE'(byte_at(cap_data, 5)), MAX_RATE'(8'h00));

        // Random modes and lengths.
        for (int t = 0; t < 16; t++) begin
            send_msg(int'($urandom_range(0, 7)), int'($urandom_range(0, 400)), -1, 1);
            wait_drain("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
